// File: rtl/ped_panel_pkg.sv
// ped_panel_pkg
//   Shared types and default constants for the pedestrian crossing panel.
//   ped_state_t : panel sequencing states (IDLE, REQ, WAIT, WALK)
//   DEF_*       : default parameter values used by the panel modules
package ped_panel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WALK = 2'd3
    } ped_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_REQ_TIMEOUT     = 16;
    localparam int unsigned DEF_CNT_W           = 3;

endpackage

// File: rtl/ped_crossing_panel_debouncer.sv
// btn_debouncer
//   Two-flop synchronizer plus counter debouncer for the crossing button.
//   Emits a registered one-cycle pulse on each accepted press (0->1 of the
//   debounced level); releases produce nothing.
//   Ports:
//     clk     : system clock, rising edge
//     reset   : asynchronous, active-high
//     btn_raw : raw asynchronous button, high = pressed
//     press   : one-cycle accepted-press pulse
module btn_debouncer
    import ped_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
                if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                    press <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ped_crossing_panel.sv
// ped_crossing_panel
//   Pedestrian-side endpoint of the controller interface: debounced button
//   presses become one-cycle ped_req pulses; ped_walk/ped_count drive the
//   WAIT, WALK and DON'T-WALK lamps and the countdown digit.
//   Optional build macro: PED_FLASH_EN (walk lamp flashes when the count is
//   at or below FLASH_THRESH, FLASH_HALF cycles per half-period).
//   Ports:
//     clk             : system clock, rising edge
//     reset           : asynchronous, active-high
//     btn_raw         : raw crossing button, high = pressed
//     ped_walk        : walk phase active, from controller
//     ped_count       : remaining walk count, from controller
//     ped_req         : one-cycle crossing request to controller
//     wait_lamp       : request registered, wait
//     walk_lamp       : WALK lamp
//     dont_walk_lamp  : DON'T-WALK lamp
//     countdown_digit : displayed remaining count (0 outside WALK)
module ped_crossing_panel
    import ped_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned REQ_TIMEOUT     = DEF_REQ_TIMEOUT,
    parameter int unsigned FLASH_THRESH    = 3,
    parameter int unsigned FLASH_HALF      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_walk,
    input  logic [CNT_W-1:0] ped_count,
    output logic             ped_req,
    output logic             wait_lamp,
    output logic             walk_lamp,
    output logic             dont_walk_lamp,
    output logic [CNT_W-1:0] countdown_digit
);

    localparam int unsigned TMO_W = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REQ_TIMEOUT < 2) begin : g_chk_tmo
        $error("REQ_TIMEOUT must be at least 2");
    end
    if (FLASH_HALF < 1) begin : g_chk_half
        $error("FLASH_HALF must be at least 1");
    end
    if (FLASH_THRESH > (2 ** CNT_W) - 1) begin : g_chk_thresh
        $error("FLASH_THRESH exceeds the ped_count range");
    end

    logic             press;
    ped_state_t       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             walk_on;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .press  (press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            cnt_q   <= ped_count;
        end
    end

    // The timeout counter also runs during the REQ cycle, so successive
    // re-issued requests are spaced exactly REQ_TIMEOUT cycles apart.
    always_comb begin
        state_d        = state_q;
        tmo_d          = '0;
        pend_d         = pend_q;
        ped_req        = 1'b0;
        wait_lamp      = 1'b0;
        walk_on        = 1'b0;
        dont_walk_lamp = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (ped_walk) begin
                    state_d = WALK;
                end else if (press) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                ped_req   = 1'b1;
                wait_lamp = 1'b1;
                tmo_d     = tmo_q + 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                wait_lamp = 1'b1;
                if (ped_walk) begin
                    state_d = WALK;
                end else if (tmo_q == TMO_W'(REQ_TIMEOUT - 1)) begin
                    state_d = REQ;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WALK: begin
                walk_on        = 1'b1;
                dont_walk_lamp = 1'b0;
                if (press) begin
                    pend_d = 1'b1;
                end
                if (!ped_walk) begin
                    if (pend_q || press) begin
                        state_d = REQ;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign countdown_digit = (state_q == WALK) ? cnt_q : '0;

`ifdef PED_FLASH_EN
    localparam int unsigned FL_W = (FLASH_HALF > 2) ? $clog2(FLASH_HALF) : 1;

    logic [FL_W-1:0] fl_cnt_q;
    logic            fl_on_q;
    logic            flashing;

    assign flashing = (32'(cnt_q) <= FLASH_THRESH);

    // Flash phase is held cleared outside WALK so every WALK entry starts lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fl_cnt_q <= '0;
            fl_on_q  <= 1'b1;
        end else if (state_q != WALK) begin
            fl_cnt_q <= '0;
            fl_on_q  <= 1'b1;
        end else if (flashing) begin
            if (fl_cnt_q == FL_W'(FLASH_HALF - 1)) begin
                fl_cnt_q <= '0;
                fl_on_q  <= ~fl_on_q;
            end else begin
                fl_cnt_q <= fl_cnt_q + 1'b1;
            end
        end
    end

    assign walk_lamp = walk_on && (!flashing || fl_on_q);
`else
    assign walk_lamp = walk_on;
`endif

endmodule
